result_bus_arbiter: RTL and testbench
=====================================

// Module: result_bus_arbiter
// PURPOSE
//  Shares the single completion (Result) bus into the commit buffer among N_REQ execution units
//  (ALU, FPU, branch, memory, ...).
//  - Each unit owns a one-entry holding slot.
//  - A round-robin scheduler picks one occupied slot per cycle and loads a registered output stage
//    that drives the commit buffer write/wakeup.
//  - Sits between the execution units and the commit buffer; flushed on branch miss.
// PARAMETERS
//  N_REQ     4    number of requesting execution units (2..8)
//  RESULT_W  50   width of packed Result: commit_id 8 + en 1 + kind 1 + content 40
// PORTS
//  clk         in   1              clock, all state updates on rising edge
//  nreset      in   1              synchronous reset, active-low
//  flush       in   1              branch miss: discard every pending result
//  req_valid   in   N_REQ          unit i presents a result
//  req_result  in   N_REQ*RESULT_W packed Result of unit i, slice [i*RESULT_W +: RESULT_W]
//  req_ready   out  N_REQ          unit i's result is taken this cycle
//  out_valid   out  1              out_result valid toward commit buffer
//  out_result  out  RESULT_W       selected Result; en bit forced to 1
//  out_ready   in   1              commit buffer accepts out_result this cycle
//  out_src     out  clog2(N_REQ)   index of unit that produced out_result (debug/perf)
// BEHAVIOUR
//  - Reset (nreset==0 at edge): all slot_valid=0, out_valid=0, out_result=0, out_src=0, rr_ptr=0.
//    Combinational outputs follow, so req_ready=all-ones after reset.
//  - Handshakes: a transfer occurs when valid&&ready. A producer must hold valid/data stable until
//    ready is asserted.
//  - Result en bit: a request whose en bit is 0 is accepted but never stored; it is dropped.
//  - Output stage:
//    - adv = !out_valid || out_ready.
//    - When adv && any slot_valid: the winner's slot moves to out_result, out_valid=1, and the
//      winner's slot clears.
//    - When adv && no slot_valid: out_valid=0.
//    - When !adv: out_result/out_src are held.
//  - Slot ready: req_ready[i] = !slot_valid[i] || (adv && grant[i]).
//    - Same-cycle free and refill is allowed, giving 1 result/cycle/unit sustained when unopposed.
//  - Latency: accept at edge t -> earliest out_valid at edge t+1 (visible cycle t+1) -> commit
//    buffer consumes at the first edge with out_ready=1.
//  - Round-robin arbitration (default):
//    - Scan slots starting at rr_ptr, wrapping N_REQ-1 -> 0. The first occupied slot is the grant.
//    - On each grant with adv: rr_ptr <= grant+1 (mod N_REQ).
//    - rr_ptr is unchanged when nothing is granted.
//  - Flush (priority over everything except reset):
//    - At the edge: all slot_valid=0 and out_valid=0, and rr_ptr is kept.
//    - req_ready reads 1 during flush and incoming requests are discarded (not stored).
//    - out_ready during flush is ignored.
//  - Boundaries:
//    - All slots full with out_ready=0: req_ready=0 for every unit; nothing is lost or overwritten.
//    - Single requester: no starvation, back-to-back output every cycle.
//    - Reset mid-transfer: the pending output is discarded; units must re-issue after reset.
// CONFIGURATION
//  RESULT_ARB_OLDEST_FIRST_EN
//   - Undefined (default): round-robin as above; no extra ports.
//   - Defined:
//     - Adds input head_id[7:0] (commit id at the commit-buffer head).
//     - Grant goes to the occupied slot with the smallest age = (commit_id - head_id) mod 256.
//     - Ties go to the lowest index; rr_ptr is not instantiated.
//     - All handshake, flush and reset rules are unchanged.
// TESTING
//  1. Reset: hold nreset=0 2 cycles with req_valid=4'b1111 -> out_valid=0, req_ready=4'b1111,
//     no slot loaded.
//  2. Round-robin fairness: all 4 units valid continuously, out_ready=1, rr_ptr=0 ->
//     out_src sequence 0,1,2,3,0,...; each unit's req_ready high exactly 1 cycle in 4.
//  3. Backpressure: all slots full, out_ready=0 for 5 cycles -> out_result stable, req_ready=0000;
//     release -> 4 distinct results drained in 4 cycles, none duplicated.
//  4. Flush: slots 1,3 full, out_valid=1, flush=1 one cycle -> next cycle out_valid=0,
//     slots empty; a unit-2 request presented during flush never appears at output.
//  5. Drop/latency: unit 0 sends commit_id=8'h2A, en=0 -> never output; unit 0 sends
//     commit_id=8'h2B, en=1 at edge t -> out_valid=1, out_src=0, id 8'h2B at cycle t+1.
//  6. With RESULT_ARB_OLDEST_FIRST_EN, head_id=8'hFE, slot0 id=8'h01, slot1 id=8'hFF ->
//     slot1 granted first (age 1 < 3), then slot0.

Source files
------------

// File: rtl/result_bus_arbiter_if.sv
// Result-bus handshake bundle between execution units, the arbiter and the commit buffer.
// The master modport is the arbiter's view; slave is the surrounding units/commit buffer.
interface result_bus_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int RESULT_W = 50
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*RESULT_W-1:0] req_result;
  logic [N_REQ-1:0]          req_ready;
  logic                      out_valid;
  logic [RESULT_W-1:0]       out_result;
  logic                      out_ready;
  logic [SRC_W-1:0]          out_src;

  modport master (
    input  req_valid, req_result, out_ready,
    output req_ready, out_valid, out_result, out_src
  );

  modport slave (
    output req_valid, req_result, out_ready,
    input  req_ready, out_valid, out_result, out_src
  );
endinterface

// File: rtl/result_bus_arbiter.sv
// Shares the commit-buffer Result bus among N_REQ units via one-entry slots and a registered output
// stage. Round-robin by default; define RESULT_ARB_OLDEST_FIRST_EN for oldest-commit-id-first grant.
module result_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int RESULT_W = 50
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                flush,
`ifdef RESULT_ARB_OLDEST_FIRST_EN
  input  logic [7:0]          head_id,
`endif
  result_bus_arbiter_if.master bus
);
  localparam int SRC_W = $clog2(N_REQ);
  // Result layout, MSB first: commit_id[7:0], en, kind, content[39:0]
  localparam int EN_BIT = RESULT_W - 9;

  logic [N_REQ-1:0]    slot_valid;
  logic [RESULT_W-1:0] slot_data [N_REQ];
  logic                adv;
  logic                any_grant;
  logic [SRC_W-1:0]    grant_idx;
  logic [N_REQ-1:0]    grant;
  logic [RESULT_W-1:0] win_data;

  assign adv = !bus.out_valid || bus.out_ready;

`ifdef RESULT_ARB_OLDEST_FIRST_EN
  localparam int ID_LSB = RESULT_W - 8;
  logic [7:0] age;
  logic [7:0] best_age;

  // Age wraps mod 256 relative to the commit head; strict compare keeps ties on the lowest index.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    best_age  = '1;
    age       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age = slot_data[i][ID_LSB +: 8] - head_id;
      if (slot_valid[i] && (!any_grant || (age < best_age))) begin
        any_grant = 1'b1;
        best_age  = age;
        grant_idx = SRC_W'(i);
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] scan_idx;
  logic [SRC_W-1:0] rr_next;

  // Scanning from the farthest offset back to rr_ptr lets the nearest occupied slot win last.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = SRC_W'((int'(rr_ptr) + k) % N_REQ);
      if (slot_valid[scan_idx]) begin
        any_grant = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign rr_next = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
`endif

  always_comb begin
    grant = '0;
    if (any_grant) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    win_data         = slot_data[grant_idx];
    win_data[EN_BIT] = 1'b1;
  end

  // A slot granted this cycle frees in time to be refilled on the same edge.
  assign bus.req_ready = {N_REQ{flush}} | ~slot_valid | (grant & {N_REQ{adv}});

  always_ff @(posedge clk) begin
    if (!nreset) begin
      slot_valid     <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_src    <= '0;
`ifndef RESULT_ARB_OLDEST_FIRST_EN
      rr_ptr         <= '0;
`endif
    end else if (flush) begin
      slot_valid    <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (adv) begin
        bus.out_valid <= any_grant;
        if (any_grant) begin
          bus.out_result <= win_data;
          bus.out_src    <= grant_idx;
`ifndef RESULT_ARB_OLDEST_FIRST_EN
          rr_ptr         <= rr_next;
`endif
        end
      end
      // Requests with en=0 complete the handshake but are never stored.
      for (int i = 0; i < N_REQ; i++) begin
        if (adv && grant[i]) slot_valid[i] <= 1'b0;
        if (bus.req_valid[i] && bus.req_ready[i] && bus.req_result[i*RESULT_W + EN_BIT]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= bus.req_result[i*RESULT_W +: RESULT_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_result_bus_arbiter;
  localparam int N  = 4;
  localparam int W  = 50;
  localparam int EN = W - 9;
  localparam int QD = 16;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic flush = 1'b0;
`ifdef RESULT_ARB_OLDEST_FIRST_EN
  logic [7:0] head_id = 8'h00;
`endif

  result_bus_arbiter_if #(.N_REQ(N), .RESULT_W(W)) bus ();

  result_bus_arbiter #(.N_REQ(N), .RESULT_W(W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .flush  (flush),
`ifdef RESULT_ARB_OLDEST_FIRST_EN
    .head_id(head_id),
`endif
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what each unit's slot holds, what sits on the output, and whose turn it is.
  logic         m_slot_v [N];
  logic [W-1:0] m_slot_d [N];
  logic         m_out_v;
  logic [W-1:0] m_out_d;
  int           m_out_src;
  int           m_ptr;
  logic [N-1:0] took;

  // Per-unit producer FIFOs of results still to be presented.
  logic [W-1:0] pbuf [N][QD];
  int           phead [N];
  int           pcnt  [N];

  function automatic logic [W-1:0] mk(input logic [7:0] id, input logic en, input logic [40:0] rest);
    return {id, en, rest};
  endfunction

  function automatic int model_winner();
    int w;
    w = -1;
`ifdef RESULT_ARB_OLDEST_FIRST_EN
    begin
      int best;
      int age;
      best = 256;
      for (int i = 0; i < N; i++) begin
        age = (int'(m_slot_d[i][W-1 -: 8]) - int'(head_id) + 256) % 256;
        if (m_slot_v[i] && age < best) begin
          best = age;
          w    = i;
        end
      end
    end
`else
    for (int k = 0; k < N; k++)
      if (w < 0 && m_slot_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
    return w;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    w = model_winner();
    for (int i = 0; i < N; i++)
      r[i] = flush || !m_slot_v[i] || ((!m_out_v || bus.out_ready) && w == i);
    return r;
  endfunction

  task automatic model_edge();
    int w;
    logic adv;
    took = '0;
    if (!nreset) begin
      for (int i = 0; i < N; i++) m_slot_v[i] = 1'b0;
      m_out_v = 1'b0; m_out_d = '0; m_out_src = 0; m_ptr = 0;
      return;
    end
    took = bus.req_valid & model_ready();
    w    = model_winner();
    adv  = !m_out_v || bus.out_ready;
    if (flush) begin
      for (int i = 0; i < N; i++) m_slot_v[i] = 1'b0;
      m_out_v = 1'b0;
      return;
    end
    if (adv) begin
      m_out_v = (w >= 0);
      if (w >= 0) begin
        m_out_d = m_slot_d[w];
        m_out_d[EN] = 1'b1;
        m_out_src = w;
        m_slot_v[w] = 1'b0;
        m_ptr = (w + 1) % N;
      end
    end
    for (int i = 0; i < N; i++)
      if (took[i] && bus.req_result[i*W + EN]) begin
        m_slot_v[i] = 1'b1;
        m_slot_d[i] = bus.req_result[i*W +: W];
      end
  endtask

  task automatic push(input int u, input logic [W-1:0] d);
    pbuf[u][(phead[u] + pcnt[u]) % QD] = d;
    pcnt[u]++;
  endtask

  task automatic clear_producers();
    for (int i = 0; i < N; i++) begin phead[i] = 0; pcnt[i] = 0; end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (pcnt[i] > 0);
      bus.req_result[i*W +: W] = (pcnt[i] > 0) ? pbuf[i][phead[i]] : '0;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++)
      if (took[i] && pcnt[i] > 0) begin
        phead[i] = (phead[i] + 1) % QD;
        pcnt[i]--;
      end
  endtask

  task automatic do_reset();
    clear_producers();
    flush = 1'b0;
    nreset = 1'b0;
    drive();
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
    clear_producers();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_result[i*W +: W] = mk(8'(i + 1), 1'b1, 41'h5);
    tick(); tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.req_ready !== 4'b1111) begin bad++; $display("[TB] FAIL reset_req_ready got=%b exp=1111", bus.req_ready); end
    total++; if (bus.out_result !== '0) begin bad++; $display("[TB] FAIL reset_out_result got=%h exp=0", bus.out_result); end
    total++; if (bus.out_src !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_src got=%0d exp=0", bus.out_src); end
    nreset = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_no_load c=%0d got=%b exp=0", c, bus.out_valid); end
      total++; if (bus.req_ready !== 4'b1111) begin bad++; $display("[TB] FAIL reset_ready_after c=%0d got=%b exp=1111", c, bus.req_ready); end
    end
  endtask

  task automatic test_round_robin();
    int seq [N];
    int rcnt [N];
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin seq[i] = 0; rcnt[i] = 0; end
    for (int c = 0; c < 17; c++) begin
      for (int i = 0; i < N; i++)
        if (pcnt[i] == 0) begin
          push(i, mk(8'(i*64 + seq[i]), 1'b1, 41'(c * 7 + i)));
          seq[i]++;
        end
      drive();
      total++; if (bus.req_ready !== model_ready()) begin bad++; $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready, model_ready()); end
      if (c >= 1) begin
        total++; if (bus.req_ready !== 4'(1 << ((c - 1) % N))) begin bad++; $display("[TB] FAIL rr_ready_onehot c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << ((c - 1) % N))); end
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) rcnt[i]++;
      end
      tick();
      total++; if (bus.out_valid !== (c >= 1)) begin bad++; $display("[TB] FAIL rr_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, (c >= 1)); end
      if (c >= 1) begin
        total++; if (bus.out_src !== 2'((c - 1) % N)) begin bad++; $display("[TB] FAIL rr_out_src c=%0d got=%0d exp=%0d", c, bus.out_src, (c - 1) % N); end
        total++; if (bus.out_result !== m_out_d) begin bad++; $display("[TB] FAIL rr_out_result c=%0d got=%h exp=%h", c, bus.out_result, m_out_d); end
      end
    end
    for (int i = 0; i < N; i++) begin
      total++; if (rcnt[i] != 4) begin bad++; $display("[TB] FAIL rr_ready_share unit=%0d got=%0d exp=4", i, rcnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_ids [4];
    exp_ids[0] = 8'h20; exp_ids[1] = 8'h30; exp_ids[2] = 8'h40; exp_ids[3] = 8'h11;
    do_reset();
    bus.out_ready = 1'b0;
    push(0, mk(8'h10, 1'b1, 41'h100)); push(0, mk(8'h11, 1'b1, 41'h101));
    push(1, mk(8'h20, 1'b1, 41'h200)); push(2, mk(8'h30, 1'b1, 41'h300));
    push(3, mk(8'h40, 1'b1, 41'h400));
    for (int c = 0; c < 2; c++) begin drive(); tick(); end
    for (int c = 0; c < 5; c++) begin
      drive();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready c=%0d got=%b exp=0000", c, bus.req_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_result[W-1 -: 8] !== 8'h10) begin bad++; $display("[TB] FAIL bp_hold c=%0d got=%b/%h exp=1/10", c, bus.out_valid, bus.out_result[W-1 -: 8]); end
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive();
      tick();
      if (c < 4) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_result[W-1 -: 8] !== exp_ids[c]) begin bad++; $display("[TB] FAIL bp_drain c=%0d got=%b/%h exp=1/%h", c, bus.out_valid, bus.out_result[W-1 -: 8], exp_ids[c]); end
      end else begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%b exp=0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b0;
    push(1, mk(8'h51, 1'b1, 41'h1)); push(1, mk(8'h52, 1'b1, 41'h2));
    push(3, mk(8'h53, 1'b1, 41'h3));
    for (int c = 0; c < 2; c++) begin drive(); tick(); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1) begin bad++; $display("[TB] FAIL flush_setup got=%b/%0d exp=1/1", bus.out_valid, bus.out_src); end
    flush = 1'b1;
    bus.out_ready = 1'b1;
    push(2, mk(8'h60, 1'b1, 41'h6));
    drive();
    total++; if (bus.req_ready !== 4'b1111) begin bad++; $display("[TB] FAIL flush_ready got=%b exp=1111", bus.req_ready); end
    tick();
    flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
    for (int c = 0; c < 4; c++) begin
      drive();
      total++; if (bus.req_ready !== 4'b1111) begin bad++; $display("[TB] FAIL flush_slots_empty c=%0d got=%b exp=1111", c, bus.req_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_discard c=%0d got=%b exp=0", c, bus.out_valid); end
    end
  endtask

  task automatic test_drop_latency();
    do_reset();
    bus.out_ready = 1'b1;
    push(0, mk(8'h2A, 1'b0, 41'h77));
    for (int c = 0; c < 4; c++) begin
      drive(); tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_en0 c=%0d got=%b exp=0", c, bus.out_valid); end
    end
    push(0, mk(8'h2B, 1'b1, 41'h88));
    drive(); tick();
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL latency_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_src !== 2'd0) begin bad++; $display("[TB] FAIL latency_src got=%0d exp=0", bus.out_src); end
    total++; if (bus.out_result !== mk(8'h2B, 1'b1, 41'h88)) begin bad++; $display("[TB] FAIL latency_result got=%h exp=%h", bus.out_result, mk(8'h2B, 1'b1, 41'h88)); end
  endtask

`ifdef RESULT_ARB_OLDEST_FIRST_EN
  task automatic test_oldest_first();
    do_reset();
    head_id = 8'hFE;
    bus.out_ready = 1'b0;
    push(0, mk(8'h01, 1'b1, 41'h1)); push(1, mk(8'hFF, 1'b1, 41'h2));
    drive(); tick();
    drive(); tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1) begin bad++; $display("[TB] FAIL oldest_first got=%b/%0d exp=1/1", bus.out_valid, bus.out_src); end
    bus.out_ready = 1'b1;
    drive(); tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_result[W-1 -: 8] !== 8'h01) begin bad++; $display("[TB] FAIL oldest_second got=%b/%0d/%h exp=1/0/01", bus.out_valid, bus.out_src, bus.out_result[W-1 -: 8]); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 99) < 3);
      nreset = !($urandom_range(0, 199) == 0);
`ifdef RESULT_ARB_OLDEST_FIRST_EN
      head_id = 8'($urandom());
`endif
      for (int i = 0; i < N; i++)
        if (pcnt[i] < 2 && $urandom_range(0, 1) == 1)
          push(i, mk(8'($urandom()), ($urandom_range(0, 99) < 85), 41'({$urandom(), $urandom()})));
      drive();
      total++; if (bus.req_ready !== model_ready()) begin bad++; $display("[TB] FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, model_ready()); end
      tick();
      total++; if (bus.out_valid !== m_out_v) begin bad++; $display("[TB] FAIL rand_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, m_out_v); end
      if (m_out_v) begin
        total++; if (bus.out_src !== 2'(m_out_src)) begin bad++; $display("[TB] FAIL rand_out_src c=%0d got=%0d exp=%0d", c, bus.out_src, m_out_src); end
        total++; if (bus.out_result !== m_out_d) begin bad++; $display("[TB] FAIL rand_out_result c=%0d got=%h exp=%h", c, bus.out_result, m_out_d); end
      end
    end
    nreset = 1'b1;
    flush  = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_result = '0;
    clear_producers();
    test_reset();
`ifndef RESULT_ARB_OLDEST_FIRST_EN
    test_round_robin();
    test_backpressure();
`else
    test_oldest_first();
`endif
    test_flush();
    test_drop_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
